// File: rtl/vc_pop_scheduler.sv
// Pop scheduler for two virtual-channel FIFOs sharing one downstream path.
// One pop per cycle at most, strict-priority or round-robin, paced by PACE.
module vc_pop_scheduler #(
  parameter int PACE   = 3,
  parameter int PACE_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vc0_empty,
  input  logic             vc1_empty,
  input  logic             out_almost_full,
  input  logic             rr_mode,
  output logic             pop_vc0,
  output logic             pop_vc1,
  output logic             valid_out,
  output logic             vc_out,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] pop_cnt_vc0,
  output logic [CNT_W-1:0] pop_cnt_vc1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Handshake: pop_vcX is a one-cycle strobe; valid_out/vc_out mark the FIFO
  // data one cycle later. out_almost_full blocks new pops, never retracts one.

  state_t            state_q, state_d;
  logic [PACE_W-1:0] gap_cnt, gap_d;
  logic              last_grant, last_grant_d;
  logic              eligible, grant0, grant1;

  always_comb begin
    eligible     = (gap_cnt == '0) && !out_almost_full && (!vc0_empty || !vc1_empty);
    grant0       = 1'b0;
    grant1       = 1'b0;
    gap_d        = gap_cnt;
    last_grant_d = last_grant;
    state_d      = IDLE;

    if (eligible) begin
      // last_grant holds the VC granted last; RR ties go to the other one
      if (rr_mode && !vc0_empty && !vc1_empty) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = !vc0_empty;
        grant1 = vc0_empty;
      end
    end

    if (grant0 || grant1) begin
      gap_d        = PACE_W'(PACE - 1);
      last_grant_d = grant1;
      state_d      = ISSUE;
    end else begin
      if (gap_cnt != '0) gap_d = gap_cnt - PACE_W'(1);
      state_d = (gap_d != '0) ? GAP : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gap_cnt     <= '0;
      last_grant  <= 1'b1;
      pop_vc0     <= 1'b0;
      pop_vc1     <= 1'b0;
      valid_out   <= 1'b0;
      vc_out      <= 1'b0;
      pop_cnt_vc0 <= '0;
      pop_cnt_vc1 <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt    <= gap_d;
      last_grant <= last_grant_d;
      pop_vc0    <= grant0;
      pop_vc1    <= grant1;
      valid_out  <= pop_vc0 || pop_vc1;
      vc_out     <= pop_vc1;
      if (grant0) pop_cnt_vc0 <= pop_cnt_vc0 + CNT_W'(1);
      if (grant1) pop_cnt_vc1 <= pop_cnt_vc1 + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Bench for vc_pop_scheduler: a PACE=3 and a PACE=1 instance share stimulus
// and are checked cycle by cycle against a pop-time based reference model.
module tb_vc_pop_scheduler;

  logic clk = 1'b0;
  logic reset, vc0_empty, vc1_empty, out_almost_full, rr_mode;

  logic       a_pop0, a_pop1, a_valid, a_vc;
  logic [1:0] a_state;
  logic [7:0] a_cnt0, a_cnt1;
  logic       b_pop0, b_pop1, b_valid, b_vc;
  logic [1:0] b_state;
  logic [7:0] b_cnt0, b_cnt1;

  always #5 clk = ~clk;

  vc_pop_scheduler #(.PACE(3), .PACE_W(2), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .out_almost_full(out_almost_full), .rr_mode(rr_mode),
    .pop_vc0(a_pop0), .pop_vc1(a_pop1), .valid_out(a_valid), .vc_out(a_vc),
    .state(a_state), .pop_cnt_vc0(a_cnt0), .pop_cnt_vc1(a_cnt1));

  vc_pop_scheduler #(.PACE(1), .PACE_W(2), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .out_almost_full(out_almost_full), .rr_mode(rr_mode),
    .pop_vc0(b_pop0), .pop_vc1(b_pop1), .valid_out(b_valid), .vc_out(b_vc),
    .state(b_state), .pop_cnt_vc0(b_cnt0), .pop_cnt_vc1(b_cnt1));

  // reference model: per instance, remember the edge index of the last pop
  int         pace [2] = '{3, 1};
  int         m_last [2];
  logic       m_lg [2], m_pop0 [2], m_pop1 [2], m_valid [2], m_vc [2];
  logic [1:0] m_state [2];
  logic [7:0] m_c0 [2], m_c1 [2];
  int         cyc = 0;

  logic [43:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_edge(input int i);
    logic g0, g1;
    bit   elig;
    if (reset) begin
      m_last[i] = -1000; m_lg[i] = 1'b1;
      m_pop0[i] = 0; m_pop1[i] = 0; m_valid[i] = 0; m_vc[i] = 0;
      m_state[i] = 2'd0; m_c0[i] = 8'd0; m_c1[i] = 8'd0;
    end else begin
      m_valid[i] = m_pop0[i] | m_pop1[i];
      m_vc[i]    = m_pop1[i];
      elig = (cyc - m_last[i] >= pace[i]) && !out_almost_full && !(vc0_empty && vc1_empty);
      g0 = 0; g1 = 0;
      if (elig) begin
        if (rr_mode && !vc0_empty && !vc1_empty) begin
          if (m_lg[i]) g0 = 1; else g1 = 1;
        end else if (!vc0_empty) g0 = 1;
        else g1 = 1;
      end
      if (g0 || g1) begin
        m_last[i] = cyc;
        m_lg[i]   = g1;
        if (g0) m_c0[i] = m_c0[i] + 8'd1;
        else    m_c1[i] = m_c1[i] + 8'd1;
        m_state[i] = 2'd1;
      end else begin
        m_state[i] = (cyc - m_last[i] <= pace[i] - 2) ? 2'd2 : 2'd0;
      end
      m_pop0[i] = g0;
      m_pop1[i] = g1;
    end
  endtask

  function automatic logic [21:0] pack(input int i);
    return {m_pop0[i], m_pop1[i], m_valid[i], m_vc[i], m_state[i], m_c0[i], m_c1[i]};
  endfunction

  task automatic step(input logic r, input logic e0, input logic e1,
                      input logic af, input logic rr);
    reset = r; vc0_empty = e0; vc1_empty = e1; out_almost_full = af; rr_mode = rr;
    model_edge(0);
    model_edge(1);
    exp_q.push_back({pack(0), pack(1)});
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // monitor: compare every registered output word against the model
  initial begin
    logic [43:0] e;
    logic [21:0] av, bv;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        av = {a_pop0, a_pop1, a_valid, a_vc, a_state, a_cnt0, a_cnt1};
        bv = {b_pop0, b_pop1, b_valid, b_vc, b_state, b_cnt0, b_cnt1};
        n_cmp += 2;
        if (av !== e[43:22]) begin
          n_bad++;
          $display("FAIL pace3 cyc%0d: got pop=%b%b v=%b vc=%b st=%0d c0=%0d c1=%0d expected pop=%b%b v=%b vc=%b st=%0d c0=%0d c1=%0d",
                   cyc, av[21], av[20], av[19], av[18], av[17:16], av[15:8], av[7:0],
                   e[43], e[42], e[41], e[40], e[39:38], e[37:30], e[29:22]);
        end
        if (bv !== e[21:0]) begin
          n_bad++;
          $display("FAIL pace1 cyc%0d: got pop=%b%b v=%b vc=%b st=%0d c0=%0d c1=%0d expected pop=%b%b v=%b vc=%b st=%0d c0=%0d c1=%0d",
                   cyc, bv[21], bv[20], bv[19], bv[18], bv[17:16], bv[15:8], bv[7:0],
                   e[21], e[20], e[19], e[18], e[17:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    reset = 1; vc0_empty = 1; vc1_empty = 1; out_almost_full = 0; rr_mode = 0;
    // reset with both empty, then idle
    repeat (2) step(1, 1, 1, 0, 0);
    check8("reset_state", {6'd0, a_state}, 8'd0);
    repeat (10) step(0, 1, 1, 0, 0);
    // strict priority, both non-empty
    repeat (9) step(0, 0, 0, 0, 0);
    // round robin, then VC0 drained
    step(1, 1, 1, 0, 1);
    repeat (8) step(0, 0, 0, 0, 1);
    repeat (6) step(0, 1, 0, 0, 1);
    // back-pressure then release
    step(1, 1, 1, 0, 0);
    repeat (5) step(0, 0, 1, 1, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    // reset during gap; first eligible edge pops immediately
    step(1, 1, 1, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    check8("gap_reset_cnt", a_cnt0, 8'd0);
    repeat (3) step(0, 0, 1, 0, 0);
    // VC1-only counter wrap on the PACE=1 instance
    step(1, 1, 1, 0, 0);
    repeat (255) step(0, 1, 0, 0, 0);
    check8("wrap_255", b_cnt1, 8'd255);
    step(0, 1, 0, 0, 0);
    check8("wrap_0", b_cnt1, 8'd0);
    check8("wrap_cnt0", b_cnt0, 8'd0);
    // randomized traffic with occasional reset and mode changes
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
           (i / 50) % 2 == 1 ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
